// File: rtl/lcd_writer.sv
// HD44780 4-bit write-only driver: power-on init, config bytes, then one byte per iWrite.
// Byte starts the cycle after acceptance; oReady is low (writes dropped) until the post-byte wait ends.
module lcd_writer #(
    parameter int P_POWERON = 750000,
    parameter int P_INIT_W1 = 205000,
    parameter int P_INIT_W2 = 5000,
    parameter int P_SETUP   = 2,
    parameter int P_EHIGH   = 12,
    parameter int P_GAP     = 50,
    parameter int P_CMD     = 2000,
    parameter int P_CLEAR   = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iWrite,
    output logic       oReady,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int P_MAX = imax(imax(imax(P_POWERON, P_INIT_W1), imax(P_INIT_W2, P_SETUP)),
                                imax(imax(P_EHIGH, P_GAP), imax(P_CMD, P_CLEAR)));
    localparam int CW = ($clog2(P_MAX + 1) > 20) ? $clog2(P_MAX + 1) : 20;

    typedef enum logic [3:0] {
        PWR_WAIT, INIT_NIB, INIT_WAIT, CFG, IDLE, HI_NIB, GAP, LO_NIB, POST_WAIT
    } state_t;

    // Every wait lasts at least one cycle, even if a parameter is set to 0.
    function automatic logic [CW-1:0] ld(input int v);
        return (v < 1) ? CW'(1) : CW'(v);
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h28;
            3'd1:    return 8'h06;
            3'd2:    return 8'h0C;
            3'd3:    return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        eph_q, eph_d;
    logic [1:0]  init_idx_q, init_idx_d;
    logic [2:0]  cfg_idx_q, cfg_idx_d;
    logic [7:0]  byte_q, byte_d;
    logic        rs_q, rs_d;
    logic        lcd_e_q, lcd_e_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic [3:0]  lcd_dat_q, lcd_dat_d;
    logic        rdy_q, rdy_d;
    logic        cnt_last;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q - CW'(1);
        eph_d      = eph_q;
        init_idx_d = init_idx_q;
        cfg_idx_d  = cfg_idx_q;
        byte_d     = byte_q;
        rs_d       = rs_q;
        cnt_last   = (cnt_q == CW'(1));

        case (state_q)
            PWR_WAIT: begin
                if (cnt_last) begin
                    state_d = INIT_NIB;
                    cnt_d   = ld(P_SETUP);
                    eph_d   = 1'b0;
                end
            end
            INIT_NIB, HI_NIB, LO_NIB: begin
                // eph_q splits each nibble into its setup window and its E-high window.
                if (cnt_last && !eph_q) begin
                    eph_d = 1'b1;
                    cnt_d = ld(P_EHIGH);
                end else if (cnt_last) begin
                    eph_d = 1'b0;
                    case (state_q)
                        INIT_NIB: begin
                            state_d = INIT_WAIT;
                            case (init_idx_q)
                                2'd0:    cnt_d = ld(P_INIT_W1);
                                2'd1:    cnt_d = ld(P_INIT_W2);
                                default: cnt_d = ld(P_CMD);
                            endcase
                        end
                        HI_NIB: begin
                            state_d = GAP;
                            cnt_d   = ld(P_GAP);
                        end
                        default: begin
                            state_d = POST_WAIT;
                            cnt_d   = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02))
                                      ? ld(P_CLEAR) : ld(P_CMD);
                        end
                    endcase
                end
            end
            INIT_WAIT: begin
                if (cnt_last && init_idx_q == 2'd3) begin
                    state_d = CFG;
                end else if (cnt_last) begin
                    state_d    = INIT_NIB;
                    init_idx_d = init_idx_q + 2'd1;
                    cnt_d      = ld(P_SETUP);
                end
            end
            CFG: begin
                state_d   = HI_NIB;
                byte_d    = cfg_byte(cfg_idx_q);
                rs_d      = 1'b0;
                cfg_idx_d = cfg_idx_q + 3'd1;
                cnt_d     = ld(P_SETUP);
                eph_d     = 1'b0;
            end
            IDLE: begin
                cnt_d = cnt_q;
                if (iWrite) begin
                    state_d = HI_NIB;
                    byte_d  = iData;
                    rs_d    = iRS;
                    cnt_d   = ld(P_SETUP);
                    eph_d   = 1'b0;
                end
            end
            GAP: begin
                if (cnt_last) begin
                    state_d = LO_NIB;
                    cnt_d   = ld(P_SETUP);
                end
            end
            POST_WAIT: begin
                if (cnt_last) begin
                    state_d = (cfg_idx_q < 3'd4) ? CFG : IDLE;
                end
            end
            default: begin
                state_d = PWR_WAIT;
                cnt_d   = ld(P_POWERON);
            end
        endcase
    end

    // Pins are registered from next-state values so they switch on the same edge as the FSM.
    always_comb begin
        lcd_dat_d = lcd_dat_q;
        lcd_rs_d  = lcd_rs_q;
        lcd_e_d   = eph_d && (state_d == INIT_NIB || state_d == HI_NIB || state_d == LO_NIB);
        rdy_d     = (state_d == IDLE);
        case (state_d)
            INIT_NIB: begin
                lcd_dat_d = (init_idx_d == 2'd3) ? 4'h2 : 4'h3;
                lcd_rs_d  = 1'b0;
            end
            HI_NIB: begin
                lcd_dat_d = byte_d[7:4];
                lcd_rs_d  = rs_d;
            end
            LO_NIB: begin
                lcd_dat_d = byte_d[3:0];
                lcd_rs_d  = rs_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= PWR_WAIT;
            cnt_q      <= ld(P_POWERON);
            eph_q      <= 1'b0;
            init_idx_q <= 2'd0;
            cfg_idx_q  <= 3'd0;
            byte_q     <= 8'h00;
            rs_q       <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_dat_q  <= 4'h0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            eph_q      <= eph_d;
            init_idx_q <= init_idx_d;
            cfg_idx_q  <= cfg_idx_d;
            byte_q     <= byte_d;
            rs_q       <= rs_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_dat_q  <= lcd_dat_d;
            rdy_q      <= rdy_d;
        end
    end

    assign oReady    = rdy_q;
    assign oLCD_E    = lcd_e_q;
    assign oLCD_RS   = lcd_rs_q;
    assign oLCD_RW   = 1'b0;
    assign oLCD_Data = lcd_dat_q;

endmodule

// File: tb/tb_lcd_writer.sv
// Directed bench for lcd_writer with small timing parameters; a negedge monitor logs E pulses.
module tb_lcd_writer;
    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] iData;
    logic       iRS;
    logic       iWrite;
    logic       oReady, oLCD_E, oLCD_RS, oLCD_RW;
    logic [3:0] oLCD_Data;

    lcd_writer #(
        .P_POWERON(20), .P_INIT_W1(8), .P_INIT_W2(4), .P_SETUP(2),
        .P_EHIGH(3), .P_GAP(5), .P_CMD(10), .P_CLEAR(30)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iData(iData), .iRS(iRS), .iWrite(iWrite),
        .oReady(oReady), .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW),
        .oLCD_Data(oLCD_Data)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int         rise_q[$], fall_q[$], setup_q[$], rdy_q[$];
    logic [3:0] nib_q[$];
    logic       rs_q[$];
    int         dchg_cyc = 0;
    int         hold_err = 0;
    logic       prev_e = 1'b0, prev_rdy = 1'b0;
    logic [3:0] prev_dat = 4'h0;
    int         n_cmp = 0, n_bad = 0;

    // Cycle numbers are edge counts: at the negedge after edge n, cyc == n.
    always @(negedge Clock) begin
        if (oLCD_Data !== prev_dat) begin
            dchg_cyc <= cyc;
            if (prev_e) hold_err <= hold_err + 1;
        end
        if (oLCD_E === 1'b1 && !prev_e) begin
            rise_q.push_back(cyc);
            setup_q.push_back((oLCD_Data !== prev_dat) ? 0 : cyc - dchg_cyc);
            nib_q.push_back(oLCD_Data);
            rs_q.push_back(oLCD_RS);
        end
        if (oLCD_E !== 1'b1 && prev_e) fall_q.push_back(cyc);
        if (oReady === 1'b1 && !prev_rdy) rdy_q.push_back(cyc);
        prev_e   <= (oLCD_E === 1'b1);
        prev_rdy <= (oReady === 1'b1);
        prev_dat <= oLCD_Data;
    end

    function automatic int b2i(input logic b);
        return (b === 1'b1) ? 1 : ((b === 1'b0) ? 0 : -1);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic clr_log();
        rise_q.delete(); fall_q.delete(); setup_q.delete(); rdy_q.delete();
        nib_q.delete(); rs_q.delete();
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (oReady !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("ready_timeout", b2i(oReady), 1);
    endtask

    task automatic wait_falls(input int k, input int budget);
        int n = 0;
        while (fall_q.size() < k && n < budget) begin
            step();
            n++;
        end
        check("fall_timeout", fall_q.size(), k);
    endtask

    // Inputs are scrambled right after the accepting edge to prove the byte was latched.
    task automatic send(input logic [7:0] d, input logic rs, output int t);
        wait_ready(300);
        iData  = d;
        iRS    = rs;
        iWrite = 1'b1;
        @(posedge Clock);
        #1;
        t      = cyc;
        iWrite = 1'b0;
        iData  = ~d;
        iRS    = ~rs;
    endtask

    task automatic check_init(input int r);
        int en[12];
        int eg[11];
        en = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};
        eg = '{10, 6, 12, 13, 7, 13, 7, 13, 7, 13, 7};
        check("init_pulses", rise_q.size(), 12);
        check("init_falls", fall_q.size(), 12);
        if (rise_q.size() == 12 && fall_q.size() == 12) begin
            check("init_first_rise", rise_q[0] - r, 22);
            for (int i = 0; i < 12; i++) begin
                check($sformatf("init_nib%0d", i), int'(nib_q[i]), en[i]);
                check($sformatf("init_rs%0d", i), b2i(rs_q[i]), 0);
                check($sformatf("init_width%0d", i), fall_q[i] - rise_q[i], 3);
            end
            for (int i = 0; i < 11; i++)
                check($sformatf("init_gap%0d", i), rise_q[i+1] - fall_q[i], eg[i]);
            check("init_rdy_count", rdy_q.size(), 1);
            if (rdy_q.size() > 0) check("init_rdy_wait", rdy_q[0] - fall_q[11], 30);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r, t;
        logic [7:0] pw_d[4];
        logic       pw_rs[4];
        int         pw_w[4];
        pw_d  = '{8'h01, 8'h01, 8'h02, 8'h03};
        pw_rs = '{1'b0, 1'b1, 1'b0, 1'b0};
        pw_w  = '{30, 10, 30, 10};

        Reset = 1'b1; iData = 8'hA5; iRS = 1'b1; iWrite = 1'b1;
        repeat (3) step();
        check("rst_ready", b2i(oReady), 0);
        check("rst_e", b2i(oLCD_E), 0);
        check("rst_rs", b2i(oLCD_RS), 0);
        check("rst_data", (^oLCD_Data === 1'bx) ? -1 : int'(oLCD_Data), 0);
        check("rst_rw", b2i(oLCD_RW), 0);
        iWrite = 1'b0;
        clr_log();
        Reset = 1'b0;
        r = cyc;
        wait_ready(1000);
        step();
        check_init(r);

        // 'H' as data: nibble timing and post-byte wait
        clr_log();
        send(8'h48, 1'b1, t);
        check("acc_ready_low", b2i(oReady), 0);
        wait_ready(300);
        step();
        check("h_pulses", rise_q.size(), 2);
        if (rise_q.size() == 2 && fall_q.size() == 2 && rdy_q.size() == 1) begin
            check("h_nib_hi", int'(nib_q[0]), 4);
            check("h_nib_lo", int'(nib_q[1]), 8);
            check("h_rs_hi", b2i(rs_q[0]), 1);
            check("h_rs_lo", b2i(rs_q[1]), 1);
            check("h_first_rise", rise_q[0] - t, 2);
            check("h_setup_hi", setup_q[0], 2);
            check("h_setup_lo", setup_q[1], 2);
            check("h_width_hi", fall_q[0] - rise_q[0], 3);
            check("h_width_lo", fall_q[1] - rise_q[1], 3);
            check("h_gap", (rise_q[1] - setup_q[1]) - fall_q[0], 5);
            check("h_post", rdy_q[0] - fall_q[1], 10);
        end

        // Post-byte wait selection: clear/home commands vs everything else
        for (int k = 0; k < 4; k++) begin
            clr_log();
            send(pw_d[k], pw_rs[k], t);
            wait_ready(300);
            step();
            check($sformatf("pw%0d_pulses", k), rise_q.size(), 2);
            if (rise_q.size() == 2 && fall_q.size() == 2 && rdy_q.size() == 1) begin
                check($sformatf("pw%0d_nib_lo", k), int'(nib_q[1]), int'(pw_d[k][3:0]));
                check($sformatf("pw%0d_rs", k), b2i(rs_q[1]), int'(pw_rs[k]));
                check($sformatf("pw%0d_post", k), rdy_q[0] - fall_q[1], pw_w[k]);
            end
        end

        // Writes while busy are dropped
        clr_log();
        send(8'h41, 1'b1, t);
        wait_falls(1, 100);
        iData = 8'h99; iRS = 1'b0; iWrite = 1'b1;
        step();
        iWrite = 1'b0;
        wait_falls(2, 100);
        repeat (3) step();
        iData = 8'h55; iRS = 1'b0; iWrite = 1'b1;
        step();
        iWrite = 1'b0;
        wait_ready(300);
        repeat (40) step();
        check("ign_pulses", rise_q.size(), 2);
        check("ign_ready", b2i(oReady), 1);
        if (rise_q.size() == 2 && fall_q.size() == 2 && rdy_q.size() == 1) begin
            check("ign_nib_hi", int'(nib_q[0]), 4);
            check("ign_nib_lo", int'(nib_q[1]), 1);
            check("ign_rs_lo", b2i(rs_q[1]), 1);
            check("ign_post", rdy_q[0] - fall_q[1], 10);
        end
        check("hold_stable", hold_err, 0);

        // Reset inside the low-nibble E-high window
        clr_log();
        send(8'h48, 1'b1, t);
        begin
            int n = 0;
            while (rise_q.size() < 2 && n < 100) begin
                step();
                n++;
            end
        end
        check("mid_e_high", b2i(oLCD_E), 1);
        Reset = 1'b1;
        step();
        check("mid_rst_e", b2i(oLCD_E), 0);
        check("mid_rst_ready", b2i(oReady), 0);
        check("mid_rst_data", int'(oLCD_Data), 0);
        step();
        clr_log();
        Reset = 1'b0;
        r = cyc;
        wait_ready(1000);
        step();
        check_init(r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
